bp_predictor_unit: RTL and testbench

//  Fetch-stage branch predictor: parametrised gshare direction table plus tagged direct-mapped BTB.

---
 rtl/bp_pkg.sv | 14 +
 rtl/bp_predictor_unit_if.sv | 46 ++++
 rtl/bp_pht.sv | 26 ++
 rtl/bp_predictor_unit.sv | 108 ++++++++++
 tb/tb_bp_predictor_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: counter encodings, widths, BTB entry layout and saturating-counter helper
package bp_pkg;
   localparam int FIP_W = 28;
   typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
   localparam ctr_t CTR_RST = WNT;
   typedef struct packed {
      logic [FIP_W-1:0] fip_e;
      logic [FIP_W-1:0] fip_o;
      logic [31:0]      eip;
   } btb_tgt_t;
   function automatic ctr_t ctr_next(input ctr_t c, input logic up);
      return up ? ((c == ST) ? ST : ctr_t'(c + 2'd1)) : ((c == SNT) ? SNT : ctr_t'(c - 2'd1));
   endfunction
endpackage

// File: rtl/bp_predictor_unit_if.sv
// bp_predictor_unit_if: fetch lookup, WB update and prediction result bundle
//  slave  : predictor side (lookup/update in, prediction/targets out)
//  master : fetch/WB side (drives lookup/update, receives prediction)
//  BP_RAS_EN adds is_call, is_ret, ret_eip
interface bp_predictor_unit_if #(parameter int GHR_BITS = 6);
   import bp_pkg::*;
   logic [31:0]         eip;
   logic                LD;
   logic                is_D_valid;
   logic                upd_valid;
   logic                upd_taken;
   logic                upd_mispredict;
   logic [GHR_BITS-1:0] upd_alias;
   logic [31:0]         upd_eip;
   logic [FIP_W-1:0]    upd_fip_e;
   logic [FIP_W-1:0]    upd_fip_o;
   logic [31:0]         upd_target;
   logic                prediction;
   logic [GHR_BITS-1:0] bp_alias;
   logic [FIP_W-1:0]    fip_e_target;
   logic [FIP_W-1:0]    fip_o_target;
   logic [31:0]         eip_target;
   logic                btb_hit;
   logic                btb_miss;
`ifdef BP_RAS_EN
   logic                is_call;
   logic                is_ret;
   logic [31:0]         ret_eip;
`endif
   modport slave (
`ifdef BP_RAS_EN
      input  is_call, is_ret, ret_eip,
`endif
      input  eip, LD, is_D_valid, upd_valid, upd_taken, upd_mispredict, upd_alias, upd_eip,
             upd_fip_e, upd_fip_o, upd_target,
      output prediction, bp_alias, fip_e_target, fip_o_target, eip_target, btb_hit, btb_miss
   );
   modport master (
`ifdef BP_RAS_EN
      output is_call, is_ret, ret_eip,
`endif
      output eip, LD, is_D_valid, upd_valid, upd_taken, upd_mispredict, upd_alias, upd_eip,
             upd_fip_e, upd_fip_o, upd_target,
      input  prediction, bp_alias, fip_e_target, fip_o_target, eip_target, btb_hit, btb_miss
   );
endinterface

// File: rtl/bp_pht.sv
// bp_pht: gshare pattern history table of 2-bit saturating counters
//  clk, reset : clock, synchronous active-high reset (all counters to weakly not-taken)
//  i_ridx     : combinational read index -> o_rctr
//  i_we/i_widx/i_up : synchronous saturating update (up on taken, down otherwise)
module bp_pht import bp_pkg::*; #(
   parameter int GHR_BITS = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [GHR_BITS-1:0] i_ridx,
   output ctr_t                o_rctr,
   input  logic                i_we,
   input  logic [GHR_BITS-1:0] i_widx,
   input  logic                i_up
);
   localparam int N = 2 ** GHR_BITS;
   ctr_t r_pht [N];
   assign o_rctr = r_pht[i_ridx];
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N; k++) r_pht[k] <= CTR_RST;
      end else if (i_we) begin
         r_pht[i_widx] <= ctr_next(r_pht[i_widx], i_up);
      end
   end
endmodule

// File: rtl/bp_predictor_unit.sv
// bp_predictor_unit: gshare direction predictor with tagged direct-mapped BTB
//  clk, reset : clock, synchronous active-high reset
//  bp (slave) : fetch lookup (eip, LD, is_D_valid), WB update (upd_*),
//               results (prediction, bp_alias, fip_e/o_target, eip_target, btb_hit, btb_miss)
//  BP_RAS_EN  : adds a return stack driven by is_call/is_ret/ret_eip
module bp_predictor_unit import bp_pkg::*; #(
   parameter int BTB_ENTRIES = 64,
   parameter int TAG_BITS    = 12,
   parameter int GHR_BITS    = 6,
   parameter int RAS_DEPTH   = 8
) (
   input logic                clk,
   input logic                reset,
   bp_predictor_unit_if.slave bp
);
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   logic                r_valid [BTB_ENTRIES];
   logic [TAG_BITS-1:0] r_tag   [BTB_ENTRIES];
   btb_tgt_t            r_tgt   [BTB_ENTRIES];
   logic [GHR_BITS-1:0] r_spec_ghr, r_arch_ghr;
   logic [IDX_W-1:0]    w_idx, w_uidx;
   logic [TAG_BITS-1:0] w_tag, w_utag;
   logic [GHR_BITS-1:0] w_alias;
   logic [1:0]          w_ctr;
   logic                w_hit, w_pred, w_recover;
   btb_tgt_t            w_tgt;
   logic                w_unused;
   assign w_idx     = bp.eip[IDX_W-1:0];
   assign w_tag     = bp.eip[IDX_W+TAG_BITS-1:IDX_W];
   assign w_uidx    = bp.upd_eip[IDX_W-1:0];
   assign w_utag    = bp.upd_eip[IDX_W+TAG_BITS-1:IDX_W];
   assign w_alias   = bp.eip[GHR_BITS-1:0] ^ r_spec_ghr;
   assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_tgt     = w_hit ? r_tgt[w_idx] : '0;
   assign w_pred    = bp.is_D_valid & w_hit & w_ctr[1];
   assign w_recover = bp.upd_valid & bp.upd_mispredict;
   assign w_unused  = ^{bp.eip[31:IDX_W+TAG_BITS], bp.upd_eip[31:IDX_W+TAG_BITS]};
   assign bp.bp_alias     = w_alias;
   assign bp.btb_hit      = w_hit;
   assign bp.btb_miss     = ~w_hit;
   assign bp.fip_e_target = w_tgt.fip_e;
   assign bp.fip_o_target = w_tgt.fip_o;
   bp_pht #(.GHR_BITS(GHR_BITS)) u_pht (
      .clk    (clk),
      .reset  (reset),
      .i_ridx (w_alias),
      .o_rctr (w_ctr),
      .i_we   (bp.upd_valid),
      .i_widx (bp.upd_alias),
      .i_up   (bp.upd_taken)
   );
`ifdef BP_RAS_EN
   localparam int SP_W = $clog2(RAS_DEPTH);
   localparam logic [SP_W:0] CNT_FULL = (SP_W + 1)'(RAS_DEPTH);
   logic [31:0]   r_ras [RAS_DEPTH];
   logic [SP_W-1:0] r_sp;
   logic [SP_W:0] r_cnt;
   logic [SP_W-1:0] w_top_sp;
   logic          w_push, w_pop;
   assign w_top_sp = r_sp - 1'b1;
   assign w_push   = bp.LD & bp.is_D_valid & bp.is_call;
   assign w_pop    = bp.LD & bp.is_D_valid & bp.is_ret & (r_cnt != '0);
   assign bp.prediction = w_pop | w_pred;
   assign bp.eip_target = w_pop ? r_ras[w_top_sp] : w_tgt.eip;
   // r_sp is the next free slot; a push when full wraps over the oldest entry
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sp  <= '0;
         r_cnt <= '0;
      end else if (w_recover) begin
         r_cnt <= '0;
      end else if (w_push && w_pop) begin
         r_ras[w_top_sp] <= bp.ret_eip;
      end else if (w_push) begin
         r_ras[r_sp] <= bp.ret_eip;
         r_sp        <= r_sp + 1'b1;
         r_cnt       <= (r_cnt == CNT_FULL) ? r_cnt : r_cnt + 1'b1;
      end else if (w_pop) begin
         r_sp  <= w_top_sp;
         r_cnt <= r_cnt - 1'b1;
      end
   end
`else
   localparam int unused_ras_depth = RAS_DEPTH;
   assign bp.prediction = w_pred;
   assign bp.eip_target = w_tgt.eip;
`endif
   // recovery rebuilds spec history from architectural history and wins over a same-cycle shift
   always_ff @(posedge clk) begin
      if (reset) begin
         r_spec_ghr <= '0;
         r_arch_ghr <= '0;
         for (int k = 0; k < BTB_ENTRIES; k++) r_valid[k] <= 1'b0;
      end else begin
         if (bp.upd_valid) r_arch_ghr <= {r_arch_ghr[GHR_BITS-2:0], bp.upd_taken};
         if (bp.upd_valid && bp.upd_taken) begin
            r_valid[w_uidx] <= 1'b1;
            r_tag[w_uidx]   <= w_utag;
         end
         if (w_recover) r_spec_ghr <= {r_arch_ghr[GHR_BITS-2:0], bp.upd_taken};
         else if (bp.LD && bp.is_D_valid && w_hit) r_spec_ghr <= {r_spec_ghr[GHR_BITS-2:0], w_pred};
      end
   end
   always_ff @(posedge clk) begin
      if (!reset && bp.upd_valid && bp.upd_taken)
         r_tgt[w_uidx] <= '{fip_e: bp.upd_fip_e, fip_o: bp.upd_fip_o, eip: bp.upd_target};
   end
endmodule

// File: tb/tb_bp_predictor_unit.sv
// tb_bp_predictor_unit: table vectors, hand sequences and random run against a reference model
module tb_bp_predictor_unit;
   import bp_pkg::*;
   localparam int GB = 6;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   bp_predictor_unit_if #(.GHR_BITS(GB)) bif();
   bp_predictor_unit #(.BTB_ENTRIES(64), .TAG_BITS(12), .GHR_BITS(GB), .RAS_DEPTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bif)
   );
   int n_vec = 0;
   int n_bad = 0;
   int m_pht [64];
   bit m_val [64];
   int m_tag [64];
   logic [31:0] m_tgt [64];
   logic [27:0] m_fe [64];
   logic [27:0] m_fo [64];
   int m_spec, m_arch;
   typedef struct {
      logic [31:0] eip;
      logic isv, ld, uv, ut, um;
      logic [5:0] ua;
      logic [31:0] ue, utg;
      logic hit, pred;
      logic [5:0] al;
      logic [31:0] tg;
   } vec_t;
   vec_t tv [$];
   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic drive(logic rst, logic [31:0] eip, logic isv, logic ld, logic uv, logic ut,
                        logic um, logic [5:0] ua, logic [31:0] ue, logic [31:0] utg);
      reset = rst;
      bif.eip = eip;
      bif.is_D_valid = isv;
      bif.LD = ld;
      bif.upd_valid = uv;
      bif.upd_taken = ut;
      bif.upd_mispredict = um;
      bif.upd_alias = ua;
      bif.upd_eip = ue;
      bif.upd_target = utg;
      bif.upd_fip_e = utg[31:4];
      bif.upd_fip_o = utg[31:4] + 28'd1;
`ifdef BP_RAS_EN
      bif.is_call = 1'b0;
      bif.is_ret = 1'b0;
      bif.ret_eip = 32'h0;
`endif
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic settle;
      #4;
   endtask
   task automatic chk(string nm, logic hit, logic pred, logic [5:0] al, logic [31:0] tg);
      cmp({nm, ".hit"}, {31'd0, bif.btb_hit}, {31'd0, hit});
      cmp({nm, ".miss"}, {31'd0, bif.btb_miss}, {31'd0, ~hit});
      cmp({nm, ".pred"}, {31'd0, bif.prediction}, {31'd0, pred});
      cmp({nm, ".alias"}, {26'd0, bif.bp_alias}, {26'd0, al});
      cmp({nm, ".tgt"}, bif.eip_target, tg);
      cmp({nm, ".fip_e"}, {4'd0, bif.fip_e_target}, hit ? {4'd0, tg[31:4]} : 32'd0);
      cmp({nm, ".fip_o"}, {4'd0, bif.fip_o_target}, hit ? {4'd0, tg[31:4] + 28'd1} : 32'd0);
   endtask
   task automatic m_reset;
      for (int i = 0; i < 64; i++) begin
         m_pht[i] = 1;
         m_val[i] = 0;
      end
      m_spec = 0;
      m_arch = 0;
   endtask
   task automatic m_look(output bit h, output bit p, output int a, output int i);
      i = int'(bif.eip % 64);
      h = m_val[i] && (m_tag[i] == int'((bif.eip / 64) % 4096));
      a = i ^ m_spec;
      p = bif.is_D_valid && h && (m_pht[a] >= 2);
   endtask
   task automatic m_check;
      bit h, p;
      int a, i;
      m_look(h, p, a, i);
      cmp("rnd.hit", {31'd0, bif.btb_hit}, {31'd0, h});
      cmp("rnd.miss", {31'd0, bif.btb_miss}, {31'd0, !h});
      cmp("rnd.pred", {31'd0, bif.prediction}, {31'd0, p});
      cmp("rnd.alias", {26'd0, bif.bp_alias}, a);
      cmp("rnd.tgt", bif.eip_target, h ? m_tgt[i] : 32'd0);
      cmp("rnd.fip_e", {4'd0, bif.fip_e_target}, h ? {4'd0, m_fe[i]} : 32'd0);
      cmp("rnd.fip_o", {4'd0, bif.fip_o_target}, h ? {4'd0, m_fo[i]} : 32'd0);
   endtask
   task automatic m_step;
      bit h, p;
      int a, i, old_arch, u;
      if (reset) begin
         m_reset();
         return;
      end
      m_look(h, p, a, i);
      old_arch = m_arch;
      if (bif.upd_valid) begin
         u = int'(bif.upd_alias);
         m_pht[u] = bif.upd_taken ? ((m_pht[u] == 3) ? 3 : m_pht[u] + 1) : ((m_pht[u] == 0) ? 0 : m_pht[u] - 1);
         m_arch = (m_arch * 2 + int'(bif.upd_taken)) % 64;
         if (bif.upd_taken) begin
            u = int'(bif.upd_eip % 64);
            m_val[u] = 1;
            m_tag[u] = int'((bif.upd_eip / 64) % 4096);
            m_tgt[u] = bif.upd_target;
            m_fe[u] = bif.upd_fip_e;
            m_fo[u] = bif.upd_fip_o;
         end
      end
      if (bif.upd_valid && bif.upd_mispredict) m_spec = (old_arch * 2 + int'(bif.upd_taken)) % 64;
      else if (bif.LD && bif.is_D_valid && h) m_spec = (m_spec * 2 + int'(p)) % 64;
   endtask
   task automatic do_reset;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      logic [31:0] e, ue;
      tv.push_back('{32'h1000, 1, 0, 0, 0, 0, 6'd0, 32'h0,    32'h0,    0, 0, 6'd0, 32'h0});
      tv.push_back('{32'h1000, 1, 0, 1, 1, 0, 6'd0, 32'h1000, 32'h2000, 0, 0, 6'd0, 32'h0});
      tv.push_back('{32'h1000, 1, 0, 0, 0, 0, 6'd0, 32'h0,    32'h0,    1, 1, 6'd0, 32'h2000});
      tv.push_back('{32'h1100, 1, 0, 0, 0, 0, 6'd0, 32'h0,    32'h0,    0, 0, 6'd0, 32'h0});
      tv.push_back('{32'h1000, 0, 0, 0, 0, 0, 6'd0, 32'h0,    32'h0,    1, 0, 6'd0, 32'h2000});
      tv.push_back('{32'h1005, 1, 0, 1, 1, 0, 6'd5, 32'h1005, 32'h3000, 0, 0, 6'd5, 32'h0});
      tv.push_back('{32'h1005, 1, 0, 1, 1, 0, 6'd5, 32'h1005, 32'h3000, 1, 1, 6'd5, 32'h3000});
      tv.push_back('{32'h1005, 1, 0, 1, 1, 0, 6'd5, 32'h1005, 32'h3000, 1, 1, 6'd5, 32'h3000});
      tv.push_back('{32'h1005, 1, 0, 1, 1, 0, 6'd5, 32'h1005, 32'h3000, 1, 1, 6'd5, 32'h3000});
      tv.push_back('{32'h1005, 1, 0, 1, 0, 0, 6'd5, 32'h1005, 32'h3000, 1, 1, 6'd5, 32'h3000});
      tv.push_back('{32'h1005, 1, 0, 1, 0, 0, 6'd5, 32'h1005, 32'h3000, 1, 1, 6'd5, 32'h3000});
      tv.push_back('{32'h1005, 1, 0, 0, 0, 0, 6'd0, 32'h0,    32'h0,    1, 0, 6'd5, 32'h3000});
      tv.push_back('{32'h1100, 1, 0, 1, 1, 0, 6'd7, 32'h1100, 32'h4000, 0, 0, 6'd0, 32'h0});
      tv.push_back('{32'h1100, 1, 0, 0, 0, 0, 6'd0, 32'h0,    32'h0,    1, 1, 6'd0, 32'h4000});
      tv.push_back('{32'h1000, 1, 0, 0, 0, 0, 6'd0, 32'h0,    32'h0,    0, 0, 6'd0, 32'h0});
      #1;
      do_reset();
      foreach (tv[i]) begin
         drive(0, tv[i].eip, tv[i].isv, tv[i].ld, tv[i].uv, tv[i].ut, tv[i].um, tv[i].ua, tv[i].ue, tv[i].utg);
         settle();
         chk($sformatf("vec%0d", i), tv[i].hit, tv[i].pred, tv[i].al, tv[i].tg);
         tick();
      end
      // history build-up: arch ends at 000001, spec untouched (LD=0)
      do_reset();
      drive(0, 0, 0, 0, 1, 1, 0, 6'h00, 32'h1000, 32'h2000); tick();
      drive(0, 0, 0, 0, 1, 1, 0, 6'h01, 32'h1001, 32'h2100); tick();
      repeat (5) begin
         drive(0, 0, 0, 0, 1, 0, 0, 6'h20, 32'h1020, 32'h0); tick();
      end
      drive(0, 0, 0, 0, 1, 1, 0, 6'h21, 32'h1021, 32'h2200); tick();
      drive(0, 32'h1000, 1, 1, 0, 0, 0, 0, 0, 0); settle(); chk("ghr_l1", 1, 1, 6'd0, 32'h2000); tick();
      drive(0, 32'h1001, 1, 1, 0, 0, 0, 0, 0, 0); settle(); chk("ghr_l2", 1, 1, 6'd0, 32'h2100); tick();
      drive(0, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0); settle(); chk("ghr_spec3", 1, 0, 6'd3, 32'h2000); tick();
      drive(0, 32'h1000, 1, 1, 1, 0, 1, 6'h20, 32'h1020, 32'h0); settle(); chk("ghr_mis", 1, 0, 6'd3, 32'h2000); tick();
      drive(0, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0); settle(); chk("ghr_rec", 1, 0, 6'd2, 32'h2000); tick();
      // reset wins over a same-cycle update
      drive(1, 32'h1000, 1, 1, 1, 1, 1, 6'd0, 32'h1030, 32'h5000); tick();
      drive(0, 32'h1030, 1, 0, 0, 0, 0, 0, 0, 0); settle(); chk("rst_mid_a", 0, 0, 6'h30, 32'h0); tick();
      drive(0, 32'h1000, 1, 0, 0, 0, 0, 0, 0, 0); settle(); chk("rst_mid_b", 0, 0, 6'h00, 32'h0); tick();
`ifdef BP_RAS_EN
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(0, 32'h2000, 1, 1, 0, 0, 0, 0, 0, 0);
         bif.is_call = 1'b1;
         bif.ret_eip = 32'h100 + i;
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         drive(0, 32'h2000, 1, 1, 0, 0, 0, 0, 0, 0);
         bif.is_ret = 1'b1;
         settle();
         cmp($sformatf("ras_pop%0d.pred", i), {31'd0, bif.prediction}, 32'd1);
         cmp($sformatf("ras_pop%0d.tgt", i), bif.eip_target, 32'h108 - i);
         tick();
      end
      drive(0, 32'h2000, 1, 1, 0, 0, 0, 0, 0, 0);
      bif.is_ret = 1'b1;
      settle();
      cmp("ras_empty.pred", {31'd0, bif.prediction}, 32'd0);
      cmp("ras_empty.tgt", bif.eip_target, 32'h0);
      tick();
      drive(0, 32'h2000, 1, 1, 0, 0, 0, 0, 0, 0);
      bif.is_call = 1'b1;
      bif.ret_eip = 32'h555;
      tick();
      drive(0, 32'h2000, 0, 0, 1, 0, 1, 6'h3f, 32'h0, 32'h0);
      tick();
      drive(0, 32'h2000, 1, 1, 0, 0, 0, 0, 0, 0);
      bif.is_ret = 1'b1;
      settle();
      cmp("ras_clr.pred", {31'd0, bif.prediction}, 32'd0);
      cmp("ras_clr.tgt", bif.eip_target, 32'h0);
      tick();
`endif
      do_reset();
      m_reset();
      for (int n = 0; n < 800; n++) begin
         e  = 32'h1000 + 32'd256 * $urandom_range(0, 1) + $urandom_range(0, 15);
         ue = 32'h1000 + 32'd256 * $urandom_range(0, 1) + $urandom_range(0, 15);
         drive(($urandom_range(0, 63) == 0), e, 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), ($urandom_range(0, 4) == 0), 6'($urandom), ue, $urandom);
         settle();
         m_check();
         m_step();
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
